// File: rtl/puf_ctrl.sv
// Delay-PUF sequencer: steps LFSR challenges through the arbiter chain and majority-votes each response bit.
// Define PUF_CTRL_CONFIDENCE_EN to add unstable_cnt, the number of bits whose votes were not unanimous.
module puf_ctrl #(
    parameter int unsigned       LENGTH    = 8,
    parameter int unsigned       RESP_BITS = 16,
    parameter int unsigned       VOTES     = 5,
    parameter int unsigned       SETTLE    = 8,
    parameter int unsigned       GAP       = 4,
    parameter logic [LENGTH-1:0] TAPS      = 8'hB8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LENGTH-1:0]    seed,
    output logic [LENGTH-1:0]    puf_challenge,
    output logic                 puf_run,
    input  logic                 puf_result,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response
`ifdef PUF_CTRL_CONFIDENCE_EN
    ,
    output logic [$clog2(RESP_BITS):0] unstable_cnt
`endif
);

    localparam int unsigned BIT_W  = $clog2(RESP_BITS) + 1;
    localparam int unsigned VOTE_W = $clog2(VOTES) + 1;
    localparam int unsigned TMAX   = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int unsigned TMR_W  = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, FIRE, COMMIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_nxt, bit_inc;
    logic [VOTE_W-1:0]   eval_cnt, eval_nxt, eval_inc;
    logic [VOTE_W-1:0]   ones_cnt, ones_nxt;
    logic [LENGTH-1:0]   seed_q, seed_nxt;
    logic [LENGTH-1:0]   chal_nxt;
    logic [RESP_BITS-1:0] resp_nxt;
    logic                run_nxt, busy_nxt, done_nxt;
    logic                maj, feedback;
`ifdef PUF_CTRL_CONFIDENCE_EN
    logic [BIT_W-1:0]    unst_nxt;
`endif

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tmr           <= '0;
            bit_cnt       <= '0;
            eval_cnt      <= '0;
            ones_cnt      <= '0;
            seed_q        <= '0;
            puf_challenge <= '0;
            puf_run       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            response      <= '0;
`ifdef PUF_CTRL_CONFIDENCE_EN
            unstable_cnt  <= '0;
`endif
        end else begin
            state         <= state_nxt;
            tmr           <= tmr_nxt;
            bit_cnt       <= bit_nxt;
            eval_cnt      <= eval_nxt;
            ones_cnt      <= ones_nxt;
            seed_q        <= seed_nxt;
            puf_challenge <= chal_nxt;
            puf_run       <= run_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            response      <= resp_nxt;
`ifdef PUF_CTRL_CONFIDENCE_EN
            unstable_cnt  <= unst_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        bit_nxt   = bit_cnt;
        eval_nxt  = eval_cnt;
        ones_nxt  = ones_cnt;
        seed_nxt  = seed_q;
        chal_nxt  = puf_challenge;
        resp_nxt  = response;
`ifdef PUF_CTRL_CONFIDENCE_EN
        unst_nxt  = unstable_cnt;
`endif
        bit_inc   = bit_cnt + BIT_W'(1);
        eval_inc  = eval_cnt + VOTE_W'(1);
        maj       = ones_cnt > VOTE_W'(VOTES / 2);
        feedback  = ^(puf_challenge & TAPS);

        case (state)
            IDLE: begin
                if (start) begin
                    seed_nxt  = seed;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // An all-zero LFSR state would lock up, so substitute 1
                chal_nxt  = (seed_q == '0) ? LENGTH'(1) : seed_q;
                resp_nxt  = '0;
                bit_nxt   = '0;
                eval_nxt  = '0;
                ones_nxt  = '0;
                tmr_nxt   = '0;
`ifdef PUF_CTRL_CONFIDENCE_EN
                unst_nxt  = '0;
`endif
                state_nxt = ARM;
            end
            ARM: begin
                if (tmr == TMR_W'(GAP - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = FIRE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            FIRE: begin
                if (tmr == TMR_W'(SETTLE - 1)) begin
                    tmr_nxt   = '0;
                    ones_nxt  = ones_cnt + VOTE_W'(puf_result);
                    eval_nxt  = eval_inc;
                    state_nxt = (eval_inc < VOTE_W'(VOTES)) ? ARM : COMMIT;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            COMMIT: begin
                resp_nxt  = {response[RESP_BITS-2:0], maj};
                chal_nxt  = {puf_challenge[LENGTH-2:0], feedback};
`ifdef PUF_CTRL_CONFIDENCE_EN
                if ((ones_cnt != '0) && (ones_cnt < VOTE_W'(VOTES)))
                    unst_nxt = unstable_cnt + BIT_W'(1);
`endif
                ones_nxt  = '0;
                eval_nxt  = '0;
                bit_nxt   = bit_inc;
                state_nxt = (bit_inc == BIT_W'(RESP_BITS)) ? DONE : ARM;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        run_nxt  = (state_nxt == FIRE);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_puf_ctrl.sv
// Bench for puf_ctrl: two instances (VOTES=1 and VOTES=5) against a cycle-position model and PUF stand-ins.
// Builds with or without PUF_CTRL_CONFIDENCE_EN.
module tb_puf_ctrl;

    localparam int RB = 16;
    localparam int G  = 4;
    localparam int S  = 8;
    localparam int M_IDEAL = 0, M_ONES = 1, M_NOISY = 2, M_ALT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_v [2];
    logic [7:0] seed_v  [2];
    logic       res_v   [2];
    logic [7:0] chal_v  [2];
    logic       run_v   [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [15:0] resp_v [2];
`ifdef PUF_CTRL_CONFIDENCE_EN
    logic [4:0] unst_v  [2];
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    puf_ctrl #(.LENGTH(8), .RESP_BITS(16), .VOTES(1), .SETTLE(8), .GAP(4), .TAPS(8'hB8)) u_dut_v1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .seed(seed_v[0]),
        .puf_challenge(chal_v[0]), .puf_run(run_v[0]), .puf_result(res_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .response(resp_v[0])
`ifdef PUF_CTRL_CONFIDENCE_EN
        , .unstable_cnt(unst_v[0])
`endif
    );

    puf_ctrl #(.LENGTH(8), .RESP_BITS(16), .VOTES(5), .SETTLE(8), .GAP(4), .TAPS(8'hB8)) u_dut_v5 (
        .clk(clk), .reset(reset), .start(start_v[1]), .seed(seed_v[1]),
        .puf_challenge(chal_v[1]), .puf_run(run_v[1]), .puf_result(res_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .response(resp_v[1])
`ifdef PUF_CTRL_CONFIDENCE_EN
        , .unstable_cnt(unst_v[1])
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int nv_of(input int i);
        return (i == 0) ? 1 : 5;
    endfunction

    function automatic int per_bit(input int i);
        return nv_of(i) * (G + S) + 1;
    endfunction

    function automatic int total_of(input int i);
        return 1 + RB * per_bit(i) + 1;
    endfunction

    // Per-evaluation result of the non-ideal PUF stand-ins
    function automatic logic pat(input int md, input int b, input int e);
        case (md)
            M_ONES:  return 1'b1;
            M_NOISY: return (e == 0 || e == 1 || e == 3);
            M_ALT:   return (b % 2 == 0) ? (e == 0 || e == 1 || e == 3) : (e == 1 || e == 4);
            default: return 1'b0;
        endcase
    endfunction

    // Number of ones the controller should collect for bit b
    function automatic int ones_for(input int md, input int b, input logic [7:0] c, input int nv);
        case (md)
            M_IDEAL: return (^c) ? nv : 0;
            M_ONES:  return nv;
            M_NOISY: return 3;
            default: return (b % 2 == 0) ? 3 : 2;
        endcase
    endfunction

    // PUF stand-ins: ideal parity with 4-cycle latency, or a fixed pattern per evaluation
    int         mode [2];
    logic [2:0] pipe [2];
    logic       run_prev [2];
    int         ev [2];
    int         bi [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mode[i] = M_IDEAL; pipe[i] = '0; run_prev[i] = 1'b0; ev[i] = 0; bi[i] = 0;
            res_v[i] = 1'b0; start_v[i] = 1'b0; seed_v[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe[i]     <= {pipe[i][1:0], run_v[i] & (^chal_v[i])};
            run_prev[i] <= run_v[i];
            if (!busy_v[i]) begin
                ev[i] <= 0;
                bi[i] <= 0;
            end else if (run_prev[i] && !run_v[i]) begin
                if (ev[i] == nv_of(i) - 1) begin
                    ev[i] <= 0;
                    bi[i] <= bi[i] + 1;
                end else begin
                    ev[i] <= ev[i] + 1;
                end
            end
            res_v[i] <= (mode[i] == M_IDEAL) ? pipe[i][2] : pat(mode[i], bi[i], ev[i]);
        end
    end

    // Inputs as seen by the DUT at each active edge
    logic       smp_reset = 1'b1;
    logic       smp_start [2];
    logic [7:0] smp_seed  [2];
    always @(posedge clk) begin
        smp_reset <= reset;
        for (int i = 0; i < 2; i++) begin
            smp_start[i] <= start_v[i];
            smp_seed[i]  <= seed_v[i];
        end
    end

    // Behavioural model: position n within a run decides every output
    bit          active [2];
    int          n [2];
    logic [7:0]  exp_ch [2][17];
    logic [15:0] exp_resp [2];
    logic [15:0] held_resp [2];
    logic [7:0]  held_ch [2];
    int          exp_unst [2];
    int          held_unst [2];

    task automatic build_exp(input int i, input logic [7:0] sd);
        logic [7:0]  c;
        logic [15:0] r;
        int          u, o;
        c = (sd == 8'h00) ? 8'h01 : sd;
        r = '0;
        u = 0;
        for (int b = 0; b < RB; b++) begin
            exp_ch[i][b] = c;
            o = ones_for(mode[i], b, c, nv_of(i));
            r = {r[14:0], (o > nv_of(i) / 2) ? 1'b1 : 1'b0};
            if (o > 0 && o < nv_of(i)) u++;
            c = {c[6:0], ^(c & 8'hB8)};
        end
        exp_ch[i][16] = c;
        exp_resp[i]   = r;
        exp_unst[i]   = u;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; n[i] = 0; held_resp[i] = '0; held_ch[i] = '0;
            held_unst[i] = 0; exp_resp[i] = '0; exp_unst[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int k, b, r;
            logic [7:0] e_ch;
            logic e_run, e_busy, e_done;
            if (smp_reset) begin
                active[i] = 1'b0; held_resp[i] = '0; held_ch[i] = '0; held_unst[i] = 0;
            end else if (active[i]) begin
                if (n[i] == total_of(i)) begin
                    active[i] = 1'b0;
                    held_resp[i] = exp_resp[i];
                    held_ch[i]   = exp_ch[i][16];
                    held_unst[i] = exp_unst[i];
                end else begin
                    n[i]++;
                end
            end else if (smp_start[i]) begin
                active[i] = 1'b1;
                n[i] = 1;
                build_exp(i, smp_seed[i]);
            end

            e_run = 1'b0; e_busy = active[i]; e_done = 1'b0; e_ch = held_ch[i];
            if (active[i] && n[i] >= 2 && n[i] < total_of(i)) begin
                k = n[i] - 2;
                b = k / per_bit(i);
                r = k % per_bit(i);
                e_ch  = exp_ch[i][b];
                e_run = (r != per_bit(i) - 1) && ((r % (G + S)) >= G);
            end else if (active[i] && n[i] == total_of(i)) begin
                e_ch   = exp_ch[i][16];
                e_done = 1'b1;
            end
            chk($sformatf("run[%0d] n=%0d", i, n[i]), 32'(run_v[i]), 32'(e_run));
            chk($sformatf("busy[%0d] n=%0d", i, n[i]), 32'(busy_v[i]), 32'(e_busy));
            chk($sformatf("done[%0d] n=%0d", i, n[i]), 32'(done_v[i]), 32'(e_done));
            chk($sformatf("challenge[%0d] n=%0d", i, n[i]), 32'(chal_v[i]), 32'(e_ch));
            if (!active[i]) begin
                chk($sformatf("response_idle[%0d]", i), 32'(resp_v[i]), 32'(held_resp[i]));
`ifdef PUF_CTRL_CONFIDENCE_EN
                chk($sformatf("unstable_idle[%0d]", i), 32'(unst_v[i]), 32'(held_unst[i]));
`endif
            end else if (e_done) begin
                chk($sformatf("response_done[%0d]", i), 32'(resp_v[i]), 32'(exp_resp[i]));
`ifdef PUF_CTRL_CONFIDENCE_EN
                chk($sformatf("unstable_done[%0d]", i), 32'(unst_v[i]), 32'(exp_unst[i]));
`endif
            end
        end
    end

    // Pulse start (called 2 time units after an edge) and return the cycle index of done
    task automatic run_one(input int i, input logic [7:0] sd, input int md, output int lat);
        mode[i]   = md;
        seed_v[i] = sd;
        start_v[i] = 1'b1;
        @(posedge clk);
        #2 start_v[i] = 1'b0;
        lat = 0;
        while (lat < 1200) begin
            @(negedge clk);
            lat++;
            if (done_v[i]) break;
        end
        if (lat >= 1200) chk($sformatf("done_timeout[%0d]", i), 32'(lat), 32'(total_of(i)));
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // start while reset is held must not make either instance busy
        repeat (3) @(posedge clk);
        #2 start_v[0] = 1'b1; start_v[1] = 1'b1;
        @(posedge clk);
        #2 start_v[0] = 1'b0; start_v[1] = 1'b0;
        @(negedge clk);
        chk("busy_under_reset_v1", 32'(busy_v[0]), 32'd0);
        chk("busy_under_reset_v5", 32'(busy_v[1]), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_response", 32'(resp_v[0]), 32'h0);
        chk("reset_challenge", 32'(chal_v[1]), 32'h0);
        @(posedge clk);
        #2;

        // Ideal PUF, seed 1, one vote: LFSR parity stream and exact latency
        run_one(0, 8'h01, M_IDEAL, lat);
        chk("latency_v1", 32'(lat), 32'd210);
        chk("model_pin_seed1", 32'(exp_resp[0]), 32'hF4CD);
        chk("response_seed1", 32'(resp_v[0]), 32'hF4CD);
        chk("challenge_after_16", 32'(chal_v[0]), 32'h4B);

        // Seed 0 behaves like seed 1; starts while busy and during DONE are ignored
        fork
            run_one(0, 8'h00, M_IDEAL, lat);
            begin
                @(posedge clk);
                repeat (50) @(posedge clk);
                #2 start_v[0] = 1'b1;
                @(posedge clk);
                #2 start_v[0] = 1'b0;
                repeat (158) @(posedge clk);
                #2 start_v[0] = 1'b1;
                @(posedge clk);
                #2 start_v[0] = 1'b0;
            end
        join
        chk("latency_seed0", 32'(lat), 32'd210);
        chk("response_seed0", 32'(resp_v[0]), 32'hF4CD);
        repeat (3) @(negedge clk);
        chk("start_at_done_ignored", 32'(busy_v[0]), 32'd0);
        @(posedge clk);
        #2;

        // Five votes: noisy 1,1,0,1,0 per bit
        run_one(1, 8'h5A, M_NOISY, lat);
        chk("latency_v5", 32'(lat), 32'd978);
        chk("response_noisy", 32'(resp_v[1]), 32'hFFFF);
`ifdef PUF_CTRL_CONFIDENCE_EN
        chk("unstable_noisy", 32'(unst_v[1]), 32'd16);
`endif
        run_one(1, 8'h33, M_ONES, lat);
        chk("response_ones", 32'(resp_v[1]), 32'hFFFF);
`ifdef PUF_CTRL_CONFIDENCE_EN
        chk("unstable_ones", 32'(unst_v[1]), 32'd0);
`endif
        run_one(1, 8'hC3, M_ALT, lat);
        chk("response_alt", 32'(resp_v[1]), 32'hAAAA);
`ifdef PUF_CTRL_CONFIDENCE_EN
        chk("unstable_alt", 32'(unst_v[1]), 32'd16);
`endif

        // Abort during FIRE of bit 7 (cycle 433 after start), then a clean rerun
        mode[1] = M_IDEAL;
        seed_v[1] = 8'h01;
        start_v[1] = 1'b1;
        @(posedge clk);
        #2 start_v[1] = 1'b0;
        repeat (432) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("fire_before_abort", 32'(run_v[1]), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("abort_run", 32'(run_v[1]), 32'd0);
        chk("abort_busy", 32'(busy_v[1]), 32'd0);
        chk("abort_done", 32'(done_v[1]), 32'd0);
        @(posedge clk);
        #2;
        run_one(1, 8'h01, M_IDEAL, lat);
        chk("latency_after_abort", 32'(lat), 32'd978);
        chk("response_after_abort", 32'(resp_v[1]), 32'hF4CD);
`ifdef PUF_CTRL_CONFIDENCE_EN
        chk("unstable_ideal", 32'(unst_v[1]), 32'd0);
`endif
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
